// File: rtl/pdm_mic_decimator.sv
// pdm_mic_decimator: front end for the on-board PDM microphone.
// Generates the mic bit clock, synchronizes and samples the PDM stream once per
// bit, and decimates it into unsigned PCM samples by counting ones over a fixed
// window (boxcar / first-order CIC). Samples leave over valid/ready with a
// sticky overrun flag.
module pdm_mic_decimator #(
    parameter int unsigned CLK_DIV_LOG2 = 5,
    parameter int unsigned DECIM        = 64,
    parameter int unsigned SAMPLE_W     = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic                mic_clk,
    output logic                mic_lrsel,
    input  logic                mic_data,
    output logic [SAMPLE_W-1:0] pcm_data,
    output logic                pcm_valid,
    input  logic                pcm_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    // Bit counter spans 0..DECIM-1; the accumulator must hold DECIM itself.
    localparam int unsigned CNT_W = $clog2(DECIM);
    localparam int unsigned ACC_W = $clog2(DECIM + 1);

    // Last clk of the mic_clk low phase: the mic has had a full low phase to settle.
    localparam logic [CLK_DIV_LOG2-1:0] STROBE_PHASE =
        CLK_DIV_LOG2'((32'd1 << (CLK_DIV_LOG2 - 1)) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DECIM - 1);

    logic [CLK_DIV_LOG2-1:0] r_div;
    logic                    r_sync_meta;
    logic                    r_sync_bit;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [ACC_W-1:0]        r_acc;
    logic [SAMPLE_W-1:0]     r_pcm_data;
    logic                    r_pcm_valid;
    logic                    r_overrun;

    logic                    w_strobe;
    logic                    w_window_done;
    logic [ACC_W-1:0]        w_sample;
    logic                    w_transfer;
    logic                    w_overrun_set;

    // Free-running mic clock divider; held at zero while disabled so mic_clk idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (!enable) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + CLK_DIV_LOG2'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous PDM data line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync_bit  <= 1'b0;
        end else begin
            r_sync_meta <= mic_data;
            r_sync_bit  <= r_sync_meta;
        end
    end

    // Sample strobe and window bookkeeping.
    assign w_strobe      = enable && (r_div == STROBE_PHASE);
    assign w_window_done = w_strobe && (r_bit_cnt == LAST_BIT);
    assign w_sample      = r_acc + ACC_W'(r_sync_bit);

    // Count ones across the window; a completed or abandoned window restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_acc     <= '0;
        end else if (!enable) begin
            r_bit_cnt <= '0;
            r_acc     <= '0;
        end else if (w_window_done) begin
            r_bit_cnt <= '0;
            r_acc     <= '0;
        end else if (w_strobe) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_acc     <= w_sample;
        end
    end

    // Handshake: a transfer is only meaningful while a sample is held.
    assign w_transfer    = r_pcm_valid && pcm_ready;
    assign w_overrun_set = w_window_done && r_pcm_valid && !pcm_ready;

    // Output holding register; a new sample always wins over a pending transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcm_data  <= '0;
            r_pcm_valid <= 1'b0;
        end else if (w_window_done) begin
            r_pcm_data  <= SAMPLE_W'(w_sample);
            r_pcm_valid <= 1'b1;
        end else if (w_transfer) begin
            r_pcm_valid <= 1'b0;
        end
    end

    // Sticky overrun; a coincident set beats the clear so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign mic_clk   = r_div[CLK_DIV_LOG2-1];
    assign mic_lrsel = 1'b0;
    assign pcm_data  = r_pcm_data;
    assign pcm_valid = r_pcm_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Directed bench for pdm_mic_decimator: table of window patterns plus
// hand-written sequences for overrun, handshake races, disable and reset.
module tb_pdm_mic_decimator;

    localparam int unsigned CLK_DIV_LOG2 = 5;
    localparam int unsigned DECIM        = 64;
    localparam int unsigned SAMPLE_W     = 7;

    // Strobe j lands on clk edge 16 + 32*j after release; window 0 ends on strobe 63.
    localparam int FIRST_VALID = 16 + 63 * 32;
    localparam int WINDOW_CLK  = 64 * 32;
    localparam int WAIT_LIMIT  = 3000;

    localparam int M_ZERO          = 0;
    localparam int M_ONE           = 1;
    localparam int M_ALT           = 2;
    localparam int M_QUARTER       = 3;
    localparam int M_LAST          = 4;
    localparam int M_FIRST         = 5;
    localparam int M_NOT_LAST      = 6;
    localparam int M_ONE_THEN_ZERO = 7;

    logic                clk;
    logic                rst_n;
    logic                enable;
    logic                mic_clk;
    logic                mic_lrsel;
    logic                mic_data;
    logic [SAMPLE_W-1:0] pcm_data;
    logic                pcm_valid;
    logic                pcm_ready;
    logic                overrun;
    logic                overrun_clr;

    int mode  = M_ONE;
    int epoch = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int mode;
        int exp_data;
    } vec_t;

    vec_t vecs[7];

    pdm_mic_decimator #(
        .CLK_DIV_LOG2(CLK_DIV_LOG2),
        .DECIM       (DECIM),
        .SAMPLE_W    (SAMPLE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mic_clk    (mic_clk),
        .mic_lrsel  (mic_lrsel),
        .mic_data   (mic_data),
        .pcm_data   (pcm_data),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PDM bit k of the current run (k counts mic_clk periods since restart).
    function automatic logic pat_bit(input int m, input int k);
        int i;
        i = k % 64;
        case (m)
            M_ZERO:          return 1'b0;
            M_ONE:           return 1'b1;
            M_ALT:           return (i % 2) == 0;
            M_QUARTER:       return (i % 4) == 0;
            M_LAST:          return i == 63;
            M_FIRST:         return i == 0;
            M_NOT_LAST:      return i != 63;
            M_ONE_THEN_ZERO: return k < 64;
            default:         return 1'b0;
        endcase
    endfunction

    // Mic model: presents the next bit just after each mic_clk rising edge.
    initial begin : feeder
        int   k;
        int   seen_epoch;
        logic prev;
        k          = 0;
        seen_epoch = epoch;
        prev       = 1'b0;
        mic_data   = pat_bit(mode, 0);
        forever begin
            @(posedge clk);
            #2;
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                k          = 0;
            end else if (mic_clk && !prev) begin
                k = k + 1;
            end
            prev     = mic_clk;
            mic_data = pat_bit(mode, k);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int m);
        rst_n = 1'b0;
        mode  = m;
        epoch = epoch + 1;
        repeat (4) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!pcm_valid && n < limit);
    endtask

    task automatic wait_mic(input logic level, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (mic_clk !== level && n < 100);
    endtask

    initial begin
        int n;
        int viol;

        vecs[0] = '{M_ONE,      64};
        vecs[1] = '{M_ZERO,      0};
        vecs[2] = '{M_ALT,      32};
        vecs[3] = '{M_QUARTER,  16};
        vecs[4] = '{M_LAST,      1};
        vecs[5] = '{M_FIRST,     1};
        vecs[6] = '{M_NOT_LAST, 63};

        rst_n       = 1'b0;
        enable      = 1'b1;
        pcm_ready   = 1'b0;
        overrun_clr = 1'b0;

        // Reset state with mic_data high, then mic clock timing.
        repeat (4) step();
        check("rst mic_clk",   int'(mic_clk),   0);
        check("rst mic_lrsel", int'(mic_lrsel), 0);
        check("rst pcm_data",  int'(pcm_data),  0);
        check("rst pcm_valid", int'(pcm_valid), 0);
        check("rst overrun",   int'(overrun),   0);
        rst_n = 1'b1;
        wait_mic(1'b1, n);
        check("first mic_clk rise", n, 16);
        wait_mic(1'b0, n);
        check("mic_clk high width", n, 16);
        wait_mic(1'b1, n);
        check("mic_clk low width", n, 16);
        check("mic_lrsel run", int'(mic_lrsel), 0);

        // Window patterns with a consumer that is always ready.
        for (int v = 0; v < 7; v++) begin
            do_reset(vecs[v].mode);
            pcm_ready = 1'b1;
            wait_valid(WAIT_LIMIT, n);
            check($sformatf("vec%0d first latency", v), n, FIRST_VALID);
            check($sformatf("vec%0d data w0", v), int'(pcm_data), vecs[v].exp_data);
            check($sformatf("vec%0d overrun", v), int'(overrun), 0);
            step();
            check($sformatf("vec%0d valid drop", v), int'(pcm_valid), 0);
            wait_valid(WAIT_LIMIT, n);
            check($sformatf("vec%0d interval", v), n + 1, WINDOW_CLK);
            check($sformatf("vec%0d data w1", v), int'(pcm_data), vecs[v].exp_data);
        end

        // Consumer stalls across two windows: overwrite sets overrun.
        do_reset(M_ONE_THEN_ZERO);
        pcm_ready = 1'b0;
        wait_valid(WAIT_LIMIT, n);
        check("ovr first data", int'(pcm_data), 64);
        repeat (WINDOW_CLK) step();
        check("ovr valid held", int'(pcm_valid), 1);
        check("ovr data new",   int'(pcm_data),  0);
        check("ovr flag set",   int'(overrun),   1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr flag cleared", int'(overrun),   0);
        check("ovr valid kept",   int'(pcm_valid), 1);
        pcm_ready = 1'b1;
        step();
        pcm_ready = 1'b0;
        check("ovr one transfer", int'(pcm_valid), 0);
        pcm_ready = 1'b1;
        step();
        pcm_ready = 1'b0;
        check("ready while idle", int'(pcm_valid), 0);

        // Transfer coincident with completion, then clear coincident with overrun.
        do_reset(M_ONE_THEN_ZERO);
        pcm_ready = 1'b0;
        wait_valid(WAIT_LIMIT, n);
        check("race first data", int'(pcm_data), 64);
        repeat (WINDOW_CLK - 1) step();
        pcm_ready = 1'b1;
        step();
        pcm_ready = 1'b0;
        check("race valid stays", int'(pcm_valid), 1);
        check("race data new",    int'(pcm_data),  0);
        check("race no overrun",  int'(overrun),   0);
        repeat (WINDOW_CLK - 1) step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("set beats clear", int'(overrun),   1);
        check("set valid stays", int'(pcm_valid), 1);

        // Disable after 30 strobes: partial window discarded.
        do_reset(M_ONE);
        pcm_ready = 1'b1;
        repeat (16 + 29 * 32 + 6) step();
        enable = 1'b0;
        epoch  = epoch + 1;
        viol   = 0;
        repeat (100) begin
            step();
            if (mic_clk || pcm_valid) viol++;
        end
        check("disabled quiet", viol, 0);
        enable = 1'b1;
        wait_valid(WAIT_LIMIT, n);
        check("reenable latency", n, FIRST_VALID);
        check("reenable data", int'(pcm_data), 64);

        // Reset pulse mid-window: same fresh start.
        do_reset(M_ALT);
        pcm_ready = 1'b1;
        repeat (16 + 29 * 32 + 6) step();
        rst_n = 1'b0;
        epoch = epoch + 1;
        #1;
        check("midrst mic_clk", int'(mic_clk),   0);
        repeat (3) step();
        rst_n = 1'b1;
        wait_valid(WAIT_LIMIT, n);
        check("midrst latency", n, FIRST_VALID);
        check("midrst data", int'(pcm_data), 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
